muldiv_iter_unit: RTL and testbench
===================================

// Module: muldiv_iter_unit
// PURPOSE
//   Iterative RV32M multiply/divide unit for the multicycle core, parametrised in XLEN.
//   It extends the ALU operation set with MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//   Operands arrive from the execute step over a start/busy/done handshake.
//   The result goes back to the control FSM and is selected onto the result mux as an extra source.
// PARAMETERS
//   XLEN    32    operand/result width; any even value >= 4
//   CNT_W   $clog2(XLEN)+1    iteration counter width (localparam, derived)
// PORTS
//   clk       in   1     core clock, all state updates on rising edge
//   rst_n     in   1     asynchronous active-low reset
//   start_i   in   1     request; sampled only when the unit is idle or done
//   kill_i    in   1     abort the in-flight operation (pipeline flush / trap)
//   op_i      in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   a_i       in   XLEN  rs1 operand (dividend / multiplicand)
//   b_i       in   XLEN  rs2 operand (divisor / multiplier)
//   busy_o    out  1     operation in progress; new start_i ignored while 1
//   done_o    out  1     one-cycle pulse; result_o valid in that cycle
//   result_o  out  XLEN  result, held stable until the next accepted start
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; busy_o=0, done_o=0, result_o=0; counters and operand regs cleared.
// - FSM states are IDLE, CALC, FIX, DONE.
//   - IDLE/DONE + start_i: latch op, operands, sign flags and magnitudes.
//     - Go to CALC, or straight to DONE for the special cases below.
//   - CALC: one iteration per cycle, exactly XLEN cycles; then FIX.
//   - FIX: apply sign correction, select hi/lo or quotient/remainder, register result_o; then DONE.
//   - DONE: done_o=1 for this single cycle, busy_o=0. Goes to IDLE, or to CALC if start_i is high again (back-to-back).
// - Latency: start_i high in cycle 0 means busy_o=1 in cycles 1..XLEN+1 and done_o=1 in cycle XLEN+2.
// - Special cases are detected at accept and give done_o=1 in cycle 1 with no CALC:
//   - Div/rem by zero: quotient = all ones; remainder = a_i.
//   - Signed overflow (DIV/REM with a=-2^(XLEN-1), b=-1): quotient = a_i; remainder = 0.
// - Multiply: unsigned shift-add on magnitudes into a 2*XLEN product register.
//   - Signedness: MUL/MULH treat both operands as signed; MULHSU treats a as signed, b as unsigned; MULHU treats both as unsigned.
//   - Negate the full 2*XLEN product if the operand signs differ (signed operands only).
//   - MUL returns product[XLEN-1:0]; the others return product[2*XLEN-1:XLEN].
// - Divide: restoring division on magnitudes, one quotient bit per cycle, XLEN+1 bit partial remainder.
//   - Quotient sign = sign(a) ^ sign(b); remainder sign = sign(a). Applies to DIV/REM only.
// - kill_i has priority over everything except reset.
//   - In CALC/FIX it forces IDLE next cycle with busy_o=0; done_o is never asserted for the killed op; result_o keeps its old value.
//   - In IDLE/DONE it blocks acceptance of a simultaneous start_i.
// - start_i while busy_o=1 is ignored: no latching, no effect on the current op.
// - Input operands may change after acceptance without affecting the result.
// - Reset asserted mid-operation returns to the reset state immediately; no done_o.
// TESTING (XLEN=32, start in cycle 0)
// - MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done_o only in cycle 34, busy_o 1 in cycles 1..33.
// - High products:
//   - MULH 0x80000000*0x80000000 -> 0x40000000
//   - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE
//   - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF
// - Division signs:
//   - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF
//   - DIVU 100/7 -> 14; REMU -> 2
//   - REM 7/0xFFFFFFFE -> 1
// - Special cases, each with done_o in cycle 1:
//   - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5
//   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0
// - Handshake:
//   - Back-to-back: start held high in the done cycle gives the next done exactly 34 cycles later.
//   - Start pulse in cycle 5 of an op is ignored.
// - Abort:
//   - kill_i in cycle 10 -> busy_o=0 in cycle 11, no done_o, result_o unchanged; new start in cycle 12 completes normally.
//   - rst_n low in cycle 20 -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies by unsigned shift-add on operand magnitudes into a 2*XLEN product.
// Divides by restoring division on magnitudes.
// Sign correction happens in a single FIX step. Divide-by-zero and signed
// overflow are resolved when the request is accepted, so they finish in one cycle.
module muldiv_iter_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic              neg_a_q, neg_b_q;
    logic [XLEN-1:0]   acc;       // product high half / partial remainder
    logic [XLEN-1:0]   lo;        // product low half / multiplier / quotient
    logic [XLEN-1:0]   opb;       // multiplicand or divisor magnitude
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   result_q;

    logic              accept, special;
    logic              a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;

    logic [XLEN:0]     mul_add, mul_sum, div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem, acc_step, lo_step;

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    // Decode the incoming request: signedness, magnitudes and the single-cycle special cases.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
        a_signed    = op_i[2] ? !op_i[0] : (op_i[1:0] != 2'b11);
        b_signed    = op_i[2] ? !op_i[0] : !op_i[1];
        neg_a       = a_signed & a_i[XLEN-1];
        neg_b       = b_signed & b_i[XLEN-1];
        mag_a       = neg_a ? -a_i : a_i;
        mag_b       = neg_b ? -b_i : b_i;
        div_zero    = op_i[2] && (b_i == '0);
        div_ovf     = op_i[2] && !op_i[0] && (a_i == MIN_NEG) && (b_i == '1);
        special     = div_zero || div_ovf;
        if (div_zero) special_res = op_i[1] ? a_i : '1;
        else          special_res = op_i[1] ? '0 : a_i;
        accept      = ((state == IDLE) || (state == DONE)) && start_i && !kill_i;
    end

    // One multiply (shift-add) or divide (restoring) iteration.
    always_comb begin
        mul_add   = lo[0] ? {1'b0, opb} : '0;
        mul_sum   = {1'b0, acc} + mul_add;
        div_shift = {acc, lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opb};
        div_rem   = div_shift[XLEN-1:0] - opb;
        if (op_q[2]) begin
            acc_step = div_ge ? div_rem : div_shift[XLEN-1:0];
            lo_step  = {lo[XLEN-2:0], div_ge};
        end else begin
            acc_step = mul_sum[XLEN:1];
            lo_step  = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Sign correction and result selection for the FIX step.
    always_comb begin
        prod     = {acc, lo};
        prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -lo : lo;
        rem_fix  = neg_a_q ? -acc : acc;
        case (op_q)
            3'd0:          fix_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          fix_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:    fix_res = quo_fix;
            default:       fix_res = rem_fix;
        endcase
    end

    // Next-state logic; kill_i overrides everything in CALC/FIX.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : CALC;
            CALC: begin
                if (kill_i)                    state_nxt = IDLE;
                else if (cnt == CNT_W'(1))     state_nxt = FIX;
            end
            FIX:  state_nxt = kill_i ? IDLE : DONE;
            DONE: begin
                if (accept) state_nxt = special ? DONE : CALC;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            acc      <= '0;
            lo       <= '0;
            opb      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q    <= op_i;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            acc     <= '0;
            lo      <= op_i[2] ? mag_a : mag_b;
            opb     <= op_i[2] ? mag_b : mag_a;
            cnt     <= CNT_W'(XLEN);
            if (special) result_q <= special_res;
        end else if (state == CALC) begin
            acc <= acc_step;
            lo  <= lo_step;
            cnt <= cnt - CNT_W'(1);
        end else if ((state == FIX) && !kill_i) begin
            result_q <= fix_res;
        end
    end

    assign busy_o   = (state == CALC) || (state == FIX);
    assign done_o   = (state == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed testbench for muldiv_iter_unit (XLEN=32).
// Inputs change on the falling edge and outputs are sampled there too.
// Cycle 0 is the cycle in which start_i is high.
module tb_muldiv_iter_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, kill_i;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_iter_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .kill_i   (kill_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called on a falling edge. Holds start_i across one rising edge, then
    // scrambles the operands to show they were latched.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a_i     = 32'hDEAD_BEEF;
        b_i     = 32'h0BAD_F00D;
    endtask

    // Counts falling edges until done_o, within a bounded budget. Checks that
    // busy_o is high on every cycle before done and low in the done cycle.
    task automatic wait_done(input int budget, output int lat, output logic busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (done_o) begin
                if (busy_o) busy_ok = 1'b0;
                lat = c;
                break;
            end
            if (!busy_o) busy_ok = 1'b0;
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int   lat;
        logic busy_ok;
        start_op(op, a, b);
        wait_done(60, lat, busy_ok);
        check({tag, "_res"}, result_o, exp);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    endtask

    initial begin
        int   lat;
        logic busy_ok;

        rst_n   = 1'b0;
        start_i = 1'b0;
        kill_i  = 1'b0;
        op_i    = '0;
        a_i     = '0;
        b_i     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_res", result_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Multiply family.
        do_op("mul",     3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        do_op("mul2",    3'd0, 32'h1234_5678, 32'h10,       32'h2345_6780, 34);
        do_op("mulh",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        do_op("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        do_op("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        do_op("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);

        // Division signs.
        do_op("div",     3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34);
        do_op("rem",     3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34);
        do_op("divu",    3'd5, 32'd100,       32'd7,        32'd14,        34);
        do_op("remu",    3'd7, 32'd100,       32'd7,        32'd2,         34);
        do_op("rem_nb",  3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,        34);
        do_op("div_min", 3'd4, 32'h8000_0000, 32'd2,        32'hC000_0000, 34);

        // Special cases: done in cycle 1.
        do_op("divu_z",  3'd5, 32'd5,         32'd0,        32'hFFFF_FFFF, 1);
        do_op("remu_z",  3'd7, 32'd5,         32'd0,        32'd5,         1);
        do_op("div_z",   3'd4, 32'd20,        32'd0,        32'hFFFF_FFFF, 1);
        do_op("rem_z",   3'd6, 32'hFFFF_FFEC, 32'd0,        32'hFFFF_FFEC, 1);
        do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);

        // Back-to-back: the second start is issued in the done cycle of the first.
        do_op("b2b_a",   3'd5, 32'd100,       32'd7,        32'd14,        34);
        do_op("b2b_b",   3'd7, 32'd100,       32'd7,        32'd2,         34);

        // A start pulse in cycle 5 of a running op must be ignored.
        start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done_o) begin
                lat = c;
                break;
            end
            if (c == 5) begin
                start_i = 1'b1;
                op_i    = 3'd5;
                a_i     = 32'd5;
                b_i     = 32'd0;
            end
            if (c == 6) start_i = 1'b0;
        end
        check("ign_res", result_o, 32'hFFFF_FFEB);
        check("ign_lat", 32'(lat), 32'd34);
        @(negedge clk);
        check("ign_idle", {31'd0, busy_o}, 32'd0);

        // kill_i together with start_i in IDLE blocks acceptance.
        op_i    = 3'd5;
        a_i     = 32'd9;
        b_i     = 32'd0;
        start_i = 1'b1;
        kill_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        kill_i  = 1'b0;
        check("ks_busy", {31'd0, busy_o}, 32'd0);
        check("ks_done", {31'd0, done_o}, 32'd0);
        @(negedge clk);
        check("ks_done2", {31'd0, done_o}, 32'd0);
        check("ks_res", result_o, 32'hFFFF_FFEB);

        // Kill in cycle 10: idle in cycle 11, no done, result unchanged.
        start_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done_o) check("kill_early_done", 32'd1, 32'd0);
        end
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        check("kill_busy", {31'd0, busy_o}, 32'd0);
        check("kill_done", {31'd0, done_o}, 32'd0);
        check("kill_res", result_o, 32'hFFFF_FFEB);
        @(negedge clk);
        check("kill_done2", {31'd0, done_o}, 32'd0);
        do_op("after_kill", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);

        // Reset asserted in cycle 20 clears everything immediately.
        start_op(3'd0, 32'd3, 32'd5);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        check("arst_done", {31'd0, done_o}, 32'd0);
        check("arst_res", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(40, lat, busy_ok);
        check("arst_nodone", 32'(lat), 32'hFFFF_FFFF);
        do_op("after_rst", 3'd0, 32'd3, 32'd5, 32'd15, 34);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
